// File: rtl/y_line_fetch.sv
// Y line fetch: turns a decoded Y line-address pair into one or two line-memory
// reads and returns both lines together on a valid/ready result channel.
module y_line_fetch #(
  parameter int                ADDR_W    = 11,
  parameter int                DATA_W    = 256,
  parameter int                RD_LAT    = 1,        // legal range 1..7
  parameter logic [ADDR_W-1:0] NULL_ADDR = 11'h7FF,
  parameter logic [ADDR_W-1:0] MAX_ADDR  = 11'h7FE
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr1,
  input  logic [ADDR_W-1:0] in_addr2,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_line1,
  output logic [DATA_W-1:0] out_line2,
  output logic              out_two,
  output logic [ADDR_W-1:0] out_addr1,
  output logic              err_range
);

  typedef enum logic [2:0] {IDLE, RD1, WAIT1, RD2, WAIT2, DONE} state_t;

  // Counter runs from 0 in the first wait cycle, so data is due when it hits RD_LAT-1.
  localparam logic [2:0] CNT_LAST = 3'(RD_LAT - 1);

  state_t            state_reg, state_next;
  logic [2:0]        cnt_reg;
  logic [ADDR_W-1:0] addr1_reg;
  logic [ADDR_W-1:0] addr2_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic              addr2_live_reg;
  logic              two_reg;
  logic              err_reg;
  logic [DATA_W-1:0] line1_reg;
  logic [DATA_W-1:0] line2_reg;

  logic accept;
  logic a1_null;
  logic a1_bad;
  logic a2_bad;
  logic a2_live;
  logic start;
  logic lat_hit;

  assign a1_null = (in_addr1 == NULL_ADDR);
  assign a1_bad  = !a1_null && (in_addr1 > MAX_ADDR);
  assign a2_bad  = (in_addr2 != NULL_ADDR) && (in_addr2 > MAX_ADDR);
  assign a2_live = (in_addr2 != NULL_ADDR) && !a2_bad;
  assign accept  = in_valid && (state_reg == IDLE);
  assign start   = accept && !a1_null && !a1_bad;
  assign lat_hit = (cnt_reg == CNT_LAST);

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    mem_rd_en  = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (start) state_next = RD1;
      end
      RD1: begin
        mem_rd_en  = 1'b1;
        state_next = WAIT1;
      end
      WAIT1: begin
        if (lat_hit) state_next = addr2_live_reg ? RD2 : DONE;
      end
      RD2: begin
        mem_rd_en  = 1'b1;
        state_next = WAIT2;
      end
      WAIT2: begin
        if (lat_hit) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // A null first address is a silent drop; only malformed addresses raise the error pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_reg        <= 1'b0;
      addr1_reg      <= NULL_ADDR;
      addr2_reg      <= NULL_ADDR;
      addr2_live_reg <= 1'b0;
      mem_addr_reg   <= NULL_ADDR;
      cnt_reg        <= 3'd0;
    end else begin
      err_reg <= accept && !a1_null && (a1_bad || a2_bad);
      if (start) begin
        addr1_reg      <= in_addr1;
        addr2_reg      <= in_addr2;
        addr2_live_reg <= a2_live;
        mem_addr_reg   <= in_addr1;
      end
      if (state_reg == WAIT1 && lat_hit && addr2_live_reg) begin
        mem_addr_reg <= addr2_reg;
      end
      if (state_reg == RD1 || state_reg == RD2) begin
        cnt_reg <= 3'd0;
      end else if (state_reg == WAIT1 || state_reg == WAIT2) begin
        cnt_reg <= cnt_reg + 3'd1;
      end
    end
  end

  // Result registers only change in the wait states, so they hold steady through DONE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      line1_reg <= '0;
      line2_reg <= '0;
      two_reg   <= 1'b0;
    end else begin
      if (state_reg == WAIT1 && lat_hit) begin
        line1_reg <= mem_rdata;
        two_reg   <= 1'b0;
        if (!addr2_live_reg) line2_reg <= '0;
      end
      if (state_reg == WAIT2 && lat_hit) begin
        line2_reg <= mem_rdata;
        two_reg   <= 1'b1;
      end
    end
  end

  assign mem_addr  = mem_addr_reg;
  assign out_line1 = line1_reg;
  assign out_line2 = line2_reg;
  assign out_two   = two_reg;
  assign out_addr1 = addr1_reg;
  assign err_range = err_reg;

endmodule

// File: tb/tb_y_line_fetch.sv
// Bench for y_line_fetch: two instances (RD_LAT=1 default range; RD_LAT=3 with
// MAX_ADDR=0x3FF) driven by directed and random pairs against a cycle-timeline model.
module tb_y_line_fetch;

  localparam logic [10:0] NULLA = 11'h7FF;

  int checks   = 0;
  int failures = 0;
  logic [31:0] salt;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset     [2];
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic [10:0]  in_addr1  [2];
  logic [10:0]  in_addr2  [2];
  logic         mem_rd_en [2];
  logic [10:0]  mem_addr  [2];
  logic [255:0] mem_rdata [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [255:0] out_line1 [2];
  logic [255:0] out_line2 [2];
  logic         out_two   [2];
  logic [10:0]  out_addr1 [2];
  logic         err_range [2];

  y_line_fetch #(.RD_LAT(1)) dut_a (
    .clock(clock), .reset(reset[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_addr1(in_addr1[0]), .in_addr2(in_addr2[0]),
    .mem_rd_en(mem_rd_en[0]), .mem_addr(mem_addr[0]), .mem_rdata(mem_rdata[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_line1(out_line1[0]), .out_line2(out_line2[0]), .out_two(out_two[0]),
    .out_addr1(out_addr1[0]), .err_range(err_range[0])
  );

  y_line_fetch #(.RD_LAT(3), .MAX_ADDR(11'h3FF)) dut_b (
    .clock(clock), .reset(reset[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_addr1(in_addr1[1]), .in_addr2(in_addr2[1]),
    .mem_rd_en(mem_rd_en[1]), .mem_addr(mem_addr[1]), .mem_rdata(mem_rdata[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_line1(out_line1[1]), .out_line2(out_line2[1]), .out_two(out_two[1]),
    .out_addr1(out_addr1[1]), .err_range(err_range[1])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [10:0] max_of(input int k);
    return (k == 0) ? 11'h7FE : 11'h3FF;
  endfunction

  function automatic logic [255:0] line_data(input logic [31:0] s, input int k, input logic [10:0] a);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) begin
      d[i*32 +: 32] = ({21'd0, a} * 32'h9E3779B1) ^ s ^ (32'(i) << 8) ^ (32'(k) << 4) ^ 32'h5A5A0001;
    end
    return d;
  endfunction

  // Line memory model: data for a strobe is driven exactly RD_LAT cycles later, junk otherwise.
  logic [10:0]  pipe_addr [2][8];
  logic         pipe_vld  [2][8];
  logic [255:0] junk      [2];

  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      pipe_vld[k][0]  <= mem_rd_en[k];
      pipe_addr[k][0] <= mem_addr[k];
      for (int s = 1; s < 8; s++) begin
        pipe_vld[k][s]  <= pipe_vld[k][s-1];
        pipe_addr[k][s] <= pipe_addr[k][s-1];
      end
      for (int i = 0; i < 8; i++) junk[k][i*32 +: 32] <= $urandom;
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      mem_rdata[k] = pipe_vld[k][lat_of(k)-1] ? line_data(salt, k, pipe_addr[k][lat_of(k)-1]) : junk[k];
    end
  end

  task automatic check_value(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_state(input int k, input string tag);
    check_value($sformatf("u%0d_%s_in_ready", k, tag), 256'(in_ready[k]), 256'd1);
    check_value($sformatf("u%0d_%s_rd_en", k, tag), 256'(mem_rd_en[k]), 256'd0);
    check_value($sformatf("u%0d_%s_mem_addr", k, tag), 256'(mem_addr[k]), 256'(NULLA));
    check_value($sformatf("u%0d_%s_out_valid", k, tag), 256'(out_valid[k]), 256'd0);
    check_value($sformatf("u%0d_%s_line1", k, tag), out_line1[k], 256'd0);
    check_value($sformatf("u%0d_%s_line2", k, tag), out_line2[k], 256'd0);
    check_value($sformatf("u%0d_%s_two", k, tag), 256'(out_two[k]), 256'd0);
    check_value($sformatf("u%0d_%s_addr1", k, tag), 256'(out_addr1[k]), 256'(NULLA));
    check_value($sformatf("u%0d_%s_err", k, tag), 256'(err_range[k]), 256'd0);
  endtask

  // Called at a negedge with the unit idle; walks the expected cycle timeline after accept.
  task automatic run_txn(input int k, input logic [10:0] a1, input logic [10:0] a2, input int hold);
    int lat;
    int d;
    int last;
    logic [10:0] mx;
    bit drop, err, two, rd_exp, valid_exp;
    logic [10:0] addr_exp;
    logic [255:0] l2_exp;
    lat  = lat_of(k);
    mx   = max_of(k);
    drop = (a1 == NULLA) || (a1 > mx);
    err  = (a1 != NULLA) && ((a1 > mx) || (a2 != NULLA && a2 > mx));
    two  = !drop && (a2 != NULLA) && (a2 <= mx);
    d    = two ? 3 + 2*lat : 2 + lat;
    last = drop ? 3 + 2*lat : d + hold;
    l2_exp = two ? line_data(salt, k, a2) : 256'd0;

    check_value($sformatf("u%0d_in_ready_pre", k), 256'(in_ready[k]), 256'd1);
    in_valid[k]  = 1'b1;
    in_addr1[k]  = a1;
    in_addr2[k]  = a2;
    out_ready[k] = 1'($urandom_range(0, 1));

    for (int j = 1; j <= last; j++) begin
      @(negedge clock);
      rd_exp    = !drop && (j == 1 || (two && j == 2 + lat));
      valid_exp = !drop && (j >= d);
      addr_exp  = (two && j >= 2 + lat) ? a2 : a1;
      check_value($sformatf("u%0d_rd_en_c%0d", k, j), 256'(mem_rd_en[k]), 256'(rd_exp));
      if (!drop) check_value($sformatf("u%0d_mem_addr_c%0d", k, j), 256'(mem_addr[k]), 256'(addr_exp));
      check_value($sformatf("u%0d_err_c%0d", k, j), 256'(err_range[k]), 256'(err && j == 1));
      check_value($sformatf("u%0d_out_valid_c%0d", k, j), 256'(out_valid[k]), 256'(valid_exp));
      check_value($sformatf("u%0d_in_ready_c%0d", k, j), 256'(in_ready[k]), 256'(drop));
      if (valid_exp) begin
        check_value($sformatf("u%0d_line1_c%0d", k, j), out_line1[k], line_data(salt, k, a1));
        check_value($sformatf("u%0d_line2_c%0d", k, j), out_line2[k], l2_exp);
        check_value($sformatf("u%0d_two_c%0d", k, j), 256'(out_two[k]), 256'(two));
        check_value($sformatf("u%0d_addr1_c%0d", k, j), 256'(out_addr1[k]), 256'(a1));
      end
      if (drop || j >= d + hold) begin
        in_valid[k] = 1'b0;
      end else begin
        in_valid[k] = 1'($urandom_range(0, 1));
        in_addr1[k] = 11'($urandom_range(0, 11'h7FE));
        in_addr2[k] = 11'($urandom_range(0, 11'h7FF));
      end
      if (!drop && j >= d + hold) out_ready[k] = 1'b1;
      else if (!drop && j >= d)   out_ready[k] = 1'b0;
      else                        out_ready[k] = 1'($urandom_range(0, 1));
    end

    if (!drop) begin
      @(negedge clock);
      check_value($sformatf("u%0d_post_out_valid", k), 256'(out_valid[k]), 256'd0);
      check_value($sformatf("u%0d_post_in_ready", k), 256'(in_ready[k]), 256'd1);
      check_value($sformatf("u%0d_post_rd_en", k), 256'(mem_rd_en[k]), 256'd0);
    end
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b0;
    $display("txn u%0d a1=%03h a2=%03h hold=%0d drop=%0d two=%0d err=%0d checks=%0d failures=%0d",
             k, a1, a2, hold, drop, two, err, checks, failures);
  endtask

  // Reset lands two cycles into a fetch; everything must clear at once and stay idle.
  task automatic reset_mid(input int k, input logic [10:0] a1, input logic [10:0] a2);
    in_valid[k]  = 1'b1;
    in_addr1[k]  = a1;
    in_addr2[k]  = a2;
    out_ready[k] = 1'b1;
    @(negedge clock);
    in_valid[k] = 1'b0;
    check_value($sformatf("u%0d_rst_rd_en_c1", k), 256'(mem_rd_en[k]), 256'd1);
    @(negedge clock);
    reset[k] = 1'b0;
    #1;
    check_reset_state(k, "rst_mid");
    @(negedge clock);
    @(negedge clock);
    reset[k] = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clock);
      check_value($sformatf("u%0d_rst_out_valid_%0d", k, j), 256'(out_valid[k]), 256'd0);
      check_value($sformatf("u%0d_rst_rd_en_%0d", k, j), 256'(mem_rd_en[k]), 256'd0);
      check_value($sformatf("u%0d_rst_in_ready_%0d", k, j), 256'(in_ready[k]), 256'd1);
      check_value($sformatf("u%0d_rst_line1_%0d", k, j), out_line1[k], 256'd0);
    end
    out_ready[k] = 1'b0;
    $display("txn u%0d reset-mid-fetch a1=%03h a2=%03h checks=%0d failures=%0d", k, a1, a2, checks, failures);
  endtask

  initial begin
    logic [10:0] a1;
    logic [10:0] a2;
    int hold;
    salt = $urandom;
    for (int k = 0; k < 2; k++) begin
      reset[k]     = 1'b1;
      in_valid[k]  = 1'b0;
      in_addr1[k]  = NULLA;
      in_addr2[k]  = NULLA;
      out_ready[k] = 1'b0;
    end
    #2;
    for (int k = 0; k < 2; k++) reset[k] = 1'b0;
    repeat (3) @(negedge clock);
    for (int k = 0; k < 2; k++) check_reset_state(k, "por");
    for (int k = 0; k < 2; k++) reset[k] = 1'b1;
    @(negedge clock);

    run_txn(0, 11'h010, 11'h011, 0);
    run_txn(0, 11'h020, NULLA,   0);
    run_txn(0, NULLA,   11'h005, 0);
    run_txn(0, 11'h030, 11'h012, 10);
    run_txn(0, 11'h040, 11'h040, 2);
    run_txn(0, 11'h7FE, 11'h000, 1);
    run_txn(1, 11'h100, 11'h2A0, 0);
    reset_mid(1, 11'h100, 11'h2A0);
    run_txn(1, 11'h050, 11'h400, 0);
    run_txn(1, 11'h500, 11'h001, 0);
    run_txn(1, 11'h3FF, 11'h3FF, 3);

    for (int n = 0; n < 50; n++) begin
      for (int k = 0; k < 2; k++) begin
        a1 = ($urandom_range(0, 9) == 0) ? NULLA : 11'($urandom_range(0, 11'h7FE));
        case ($urandom_range(0, 3))
          0:       a2 = NULLA;
          1:       a2 = a1;
          2:       a2 = a1 + 11'd1;
          default: a2 = 11'($urandom_range(0, 11'h7FF));
        endcase
        hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
        run_txn(k, a1, a2, hold);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
